operand_fetch_stage: RTL
========================

# operand_fetch_stage

Pipeline stage between instruction decode and execute. Reads two source operands from the 24-bit register file through its asynchronous read ports and applies EX/MEM result forwarding. Detects load-use hazards and stalls decode for them. Registers the resolved operands into a valid/ready output slot that feeds the ALU stage.

## Interface
- DATA_BUS_WIDTH, 24, operand/result width
- REGFILE_ADDR_BITS, 4, register address width (16 registers, r0 hard-wired zero)
- STALL_CNT_BITS, 16, width of the saturating stall counter
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs1, in_rs2  in  REGFILE_ADDR_BITS  source register addresses
- in_use_rs2  in  1  instruction reads rs2 (otherwise B = immediate)
- in_imm  in  DATA_BUS_WIDTH  sign-extended immediate
- in_rd  in  REGFILE_ADDR_BITS  destination register
- in_writes_rd  in  1  instruction writes rd
- rf_read_addr1, rf_read_addr2  out  REGFILE_ADDR_BITS  to register file read ports; combinationally equal to in_rs1/in_rs2
- rf_read_data1, rf_read_data2  in  DATA_BUS_WIDTH  asynchronous read data; r0 reads 0
- ex_valid, ex_writes_rd, ex_is_load  in  1 each  state of instruction currently in execute
- ex_rd  in  REGFILE_ADDR_BITS; ex_result  in  DATA_BUS_WIDTH  ALU result in execute
- mem_valid, mem_writes_rd  in  1 each; mem_rd  in  REGFILE_ADDR_BITS; mem_result  in  DATA_BUS_WIDTH  memory-stage result
- flush  in  1  kill in-flight and incoming instruction (branch redirect)
- out_valid  out  1; out_ready  in  1  handshake to execute
- out_a, out_b  out  DATA_BUS_WIDTH  resolved operands
- out_rd  out  REGFILE_ADDR_BITS; out_writes_rd  out  1
- stall_count  out  STALL_CNT_BITS  saturating count of load-use stall cycles

## Operation
- Source select per operand, highest priority first:
  - address 0 gives 0;
  - EX match (ex_valid & ex_writes_rd & !ex_is_load & ex_rd==rs) gives ex_result;
  - MEM match (mem_valid & mem_writes_rd & mem_rd==rs) gives mem_result;
  - otherwise rf_read_data.
- No writeback forwarding: the register file writes on negedge, so a WB value is readable before the next rising edge.
- B operand: forwarded rs2 value if in_use_rs2, else in_imm.
- Load-use hazard: in_valid & ex_valid & ex_is_load & ex_writes_rd & ex_rd!=0 & (ex_rd==in_rs1 | (in_use_rs2 & ex_rd==in_rs2)).
  - Hazard forces in_ready=0.
  - If the output slot drains the same cycle, a bubble enters (out_valid=0).
- in_ready = !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready & !flush. On accept, output slot loads operands, rd and writes_rd; out_valid=1.
- Output slot drains with no accept (out_valid & out_ready): out_valid=0, data held.
- Slot full and out_ready=0: all outputs hold stable. out_valid never drops without out_ready.
- flush: out_valid=0 next edge and no accept that cycle, regardless of hazard or out_ready.
- stall_count increments each cycle the hazard is asserted; saturates at all-ones. flush does not clear it.
- Stage states: EMPTY (out_valid=0), FULL (out_valid=1, waiting), STALL (hazard asserted).
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without accept.
  - FULL to FULL on drain with accept.
  - STALL is left when the load exits EX.

## Timing
- Latency one cycle: accepted at edge k gives out_valid and operands valid after edge k.
- Hazard, in_ready and rf_read_addr* are combinational from the current-cycle inputs. No other combinational paths to outputs; out_* come from registers only.
- Load-use costs exactly one bubble when EX advances every cycle.
- Reset (synchronous) wins over flush and accept:
  - out_valid=0;
  - out_a, out_b, out_rd=0;
  - out_writes_rd=0;
  - stall_count=0.
- Reset mid-stall: after the edge the stage is EMPTY. in_ready then depends only on the hazard inputs.

## Structure
- Shared package/header holds DATA_BUS_WIDTH, REGFILE_ADDR_BITS and NUM_REGISTERS, the same constants the register file uses.
- One sub-module, fwd_mux: a combinational per-operand source select (zero/EX/MEM/RF). It is instantiated twice.
- Hazard detect, output slot and stall counter live in the top module.

## Test plan
- r3=0x000010 in RF; issue rs1=3, rs2=0 with no EX/MEM matches. Expect out_a=0x000010, out_b=0 one cycle after accept.
- EX holds rd=5, result 0xABCDEF; MEM holds rd=5, result 0x111111; issue rs1=5. Expect out_a=0xABCDEF (EX wins). Repeat with ex_rd=0, rs1=0: expect out_a=0.
- EX is a load to r7; issue rs1=7. Expect in_ready=0, one bubble, stall_count=1. Next cycle the load is in MEM with mem_result=0x00C0DE; expect accept and out_a=0x00C0DE.
- Slot full with out_ready=0 for 3 cycles. Expect out_* stable and in_ready=0; release gives one transfer and no duplicate.
- flush together with in_valid and a full slot. Expect out_valid=0 next cycle and the instruction dropped.
- Force the hazard for 70000 cycles at STALL_CNT_BITS=16. Expect stall_count=0xFFFF; reset mid-stall gives stall_count=0 and out_valid=0.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and types for the operand fetch stage.
// DATA_BUS_WIDTH, REGFILE_ADDR_BITS and NUM_REGISTERS are the same values
// the register file is built with, so both sides agree on operand shape.
// stage_state_e names the occupancy of the output slot.
// fwd_src_e names where a forwarded operand comes from.
package operand_fetch_stage_pkg;

  localparam int DATA_BUS_WIDTH    = 24;
  localparam int REGFILE_ADDR_BITS = 4;
  localparam int NUM_REGISTERS     = 1 << REGFILE_ADDR_BITS;

  typedef logic [DATA_BUS_WIDTH-1:0]    data_t;
  typedef logic [REGFILE_ADDR_BITS-1:0] reg_addr_t;

  // EMPTY: no instruction held. FULL: instruction waiting for execute.
  // STALL: a load-use hazard blocked decode and left the slot empty.
  typedef enum logic [1:0] {
    STAGE_EMPTY = 2'b00,
    STAGE_FULL  = 2'b01,
    STAGE_STALL = 2'b10
  } stage_state_e;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'b00,
    SRC_EX   = 2'b01,
    SRC_MEM  = 2'b10,
    SRC_RF   = 2'b11
  } fwd_src_e;

endpackage

// File: rtl/operand_fetch_stage_fwd_mux.sv
// fwd_mux: combinational source select for one source operand.
// Ports:
//   i_rs                          source register address
//   i_rfData                      asynchronous register file read data
//   i_exValid/i_exWritesRd/i_exIsLoad/i_exRd/i_exResult  execute-stage state
//   i_memValid/i_memWritesRd/i_memRd/i_memResult          memory-stage state
//   o_operand                     resolved operand value
module fwd_mux
  import operand_fetch_stage_pkg::*;
(
  input  logic [REGFILE_ADDR_BITS-1:0] i_rs,
  input  logic [DATA_BUS_WIDTH-1:0]    i_rfData,
  input  logic                         i_exValid,
  input  logic                         i_exWritesRd,
  input  logic                         i_exIsLoad,
  input  logic [REGFILE_ADDR_BITS-1:0] i_exRd,
  input  logic [DATA_BUS_WIDTH-1:0]    i_exResult,
  input  logic                         i_memValid,
  input  logic                         i_memWritesRd,
  input  logic [REGFILE_ADDR_BITS-1:0] i_memRd,
  input  logic [DATA_BUS_WIDTH-1:0]    i_memResult,
  output logic [DATA_BUS_WIDTH-1:0]    o_operand
);

  fwd_src_e w_src;

  // Priority select: r0 is always zero, then the youngest producer wins.
  // A load in EX has no data yet, so it is never an EX forwarding source;
  // the top stalls instead.
  always_comb begin
    w_src = SRC_RF;
    if (i_rs == '0) begin
      w_src = SRC_ZERO;
    end else if (i_exValid && i_exWritesRd && !i_exIsLoad && (i_exRd == i_rs)) begin
      w_src = SRC_EX;
    end else if (i_memValid && i_memWritesRd && (i_memRd == i_rs)) begin
      w_src = SRC_MEM;
    end
  end

  // Operand data mux driven by the select above.
  always_comb begin
    o_operand = i_rfData;
    case (w_src)
      SRC_ZERO: o_operand = '0;
      SRC_EX:   o_operand = i_exResult;
      SRC_MEM:  o_operand = i_memResult;
      default:  o_operand = i_rfData;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: sits between decode and execute. Reads two source
// operands from the register file, applies EX/MEM forwarding, stalls decode
// on load-use hazards and registers the result into a valid/ready slot.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   in_valid/in_ready           handshake from decode
//   in_rs1/in_rs2/in_use_rs2    source registers; B is in_imm when !in_use_rs2
//   in_imm, in_rd, in_writes_rd immediate, destination, destination enable
//   rf_read_addr1/2, rf_read_data1/2  register file asynchronous read ports
//   ex_*, mem_*                 state of the instructions in execute / memory
//   flush                       kills held and incoming instruction
//   out_valid/out_ready         handshake to execute
//   out_a/out_b/out_rd/out_writes_rd  registered resolved instruction
//   stall_count                 saturating count of load-use stall cycles
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REGFILE_ADDR_BITS-1:0] in_rs1,
  input  logic [REGFILE_ADDR_BITS-1:0] in_rs2,
  input  logic                         in_use_rs2,
  input  logic [DATA_BUS_WIDTH-1:0]    in_imm,
  input  logic [REGFILE_ADDR_BITS-1:0] in_rd,
  input  logic                         in_writes_rd,
  output logic [REGFILE_ADDR_BITS-1:0] rf_read_addr1,
  output logic [REGFILE_ADDR_BITS-1:0] rf_read_addr2,
  input  logic [DATA_BUS_WIDTH-1:0]    rf_read_data1,
  input  logic [DATA_BUS_WIDTH-1:0]    rf_read_data2,
  input  logic                         ex_valid,
  input  logic                         ex_writes_rd,
  input  logic                         ex_is_load,
  input  logic [REGFILE_ADDR_BITS-1:0] ex_rd,
  input  logic [DATA_BUS_WIDTH-1:0]    ex_result,
  input  logic                         mem_valid,
  input  logic                         mem_writes_rd,
  input  logic [REGFILE_ADDR_BITS-1:0] mem_rd,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_result,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_BUS_WIDTH-1:0]    out_a,
  output logic [DATA_BUS_WIDTH-1:0]    out_b,
  output logic [REGFILE_ADDR_BITS-1:0] out_rd,
  output logic                         out_writes_rd,
  output logic [STALL_CNT_BITS-1:0]    stall_count
);

  stage_state_e                r_state;
  stage_state_e                w_nextState;
  logic [DATA_BUS_WIDTH-1:0]   r_outA;
  logic [DATA_BUS_WIDTH-1:0]   r_outB;
  logic [REGFILE_ADDR_BITS-1:0] r_outRd;
  logic                        r_outWritesRd;
  logic [STALL_CNT_BITS-1:0]   r_stallCount;

  logic [DATA_BUS_WIDTH-1:0]   w_fwdRs1;
  logic [DATA_BUS_WIDTH-1:0]   w_fwdRs2;
  logic [DATA_BUS_WIDTH-1:0]   w_operandB;
  logic                        w_slotFull;
  logic                        w_slotFree;
  logic                        w_loadInEx;
  logic                        w_hazard;
  logic                        w_accept;

  assign rf_read_addr1 = in_rs1;
  assign rf_read_addr2 = in_rs2;

  fwd_mux u_fwdRs1 (
    .i_rs          (in_rs1),
    .i_rfData      (rf_read_data1),
    .i_exValid     (ex_valid),
    .i_exWritesRd  (ex_writes_rd),
    .i_exIsLoad    (ex_is_load),
    .i_exRd        (ex_rd),
    .i_exResult    (ex_result),
    .i_memValid    (mem_valid),
    .i_memWritesRd (mem_writes_rd),
    .i_memRd       (mem_rd),
    .i_memResult   (mem_result),
    .o_operand     (w_fwdRs1)
  );

  fwd_mux u_fwdRs2 (
    .i_rs          (in_rs2),
    .i_rfData      (rf_read_data2),
    .i_exValid     (ex_valid),
    .i_exWritesRd  (ex_writes_rd),
    .i_exIsLoad    (ex_is_load),
    .i_exRd        (ex_rd),
    .i_exResult    (ex_result),
    .i_memValid    (mem_valid),
    .i_memWritesRd (mem_writes_rd),
    .i_memRd       (mem_rd),
    .i_memResult   (mem_result),
    .o_operand     (w_fwdRs2)
  );

  assign w_operandB = in_use_rs2 ? w_fwdRs2 : in_imm;

  // A load to r0 produces nothing that could be consumed, so it never stalls.
  assign w_loadInEx = ex_valid & ex_is_load & ex_writes_rd & (ex_rd != '0);
  assign w_hazard   = in_valid & w_loadInEx &
                      ((ex_rd == in_rs1) | (in_use_rs2 & (ex_rd == in_rs2)));

  assign w_slotFull = (r_state == STAGE_FULL);
  assign w_slotFree = !w_slotFull | out_ready;
  assign in_ready   = !w_hazard & w_slotFree;
  assign w_accept   = in_valid & in_ready & !flush;

  // Next-state logic for the output slot. flush beats everything; an
  // accept refills the slot even while it drains; a hazard that leaves the
  // slot empty is recorded as STALL, which behaves like EMPTY downstream.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = STAGE_EMPTY;
    end else if (w_accept) begin
      w_nextState = STAGE_FULL;
    end else if (w_slotFree) begin
      w_nextState = w_hazard ? STAGE_STALL : STAGE_EMPTY;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STAGE_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Operand payload only changes on accept, so it holds through drains
  // and back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outA        <= '0;
      r_outB        <= '0;
      r_outRd       <= '0;
      r_outWritesRd <= 1'b0;
    end else if (w_accept) begin
      r_outA        <= w_fwdRs1;
      r_outB        <= w_operandB;
      r_outRd       <= in_rd;
      r_outWritesRd <= in_writes_rd;
    end
  end

  // Saturating load-use stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCount <= '0;
    end else if (w_hazard && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign out_valid     = (r_state == STAGE_FULL);
  assign out_a         = r_outA;
  assign out_b         = r_outB;
  assign out_rd        = r_outRd;
  assign out_writes_rd = r_outWritesRd;
  assign stall_count   = r_stallCount;

endmodule
